// File: rtl/fermat_pkg.sv
// rtl/fermat_pkg.sv - shared helpers for the Fermat-modulus reduction pipeline
package fermat_pkg;

    // Modulus 2^n + 1 for a given exponent
    function automatic int modulus(input int n);
        return (1 << n) + 1;
    endfunction

    // Signed residue width: covers [-(2^n-1), 2^(n+1)-1]
    function automatic int res_width(input int n);
        return n + 2;
    endfunction

    // LSB index of a lane inside a packed multi-lane bus
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/fermat_fold.sv
// rtl/fermat_fold.sv - one fold step: x = H*2^N + L  ->  L - H
module fermat_fold
    import fermat_pkg::*;
#(
    parameter int N    = 8,
    parameter int W_IN = 2 * N + 1
) (
    input  logic signed [W_IN-1:0]         x,
    output logic signed [res_width(N)-1:0] y
);

    localparam int RW = res_width(N);
    localparam int HW = W_IN - N;

    logic signed [HW-1:0] hi;
    logic signed [RW-1:0] lo_ext;
    logic signed [RW-1:0] hi_ext;

    // Low part is unsigned, high part carries the sign of x
    assign hi     = x[W_IN-1:N];
    assign lo_ext = {2'b00, x[N-1:0]};
    assign hi_ext = {{(RW - HW){hi[HW-1]}}, hi};
    assign y      = lo_ext - hi_ext;

endmodule

// File: rtl/fermat_reduce_pipe.sv
// rtl/fermat_reduce_pipe.sv - 3-stage multi-lane reduction modulo 2^N+1
module fermat_reduce_pipe
    import fermat_pkg::*;
#(
    parameter int N     = 8,
    parameter int LANES = 4,
    parameter int IN_W  = 2 * N + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_lazy,
    input  logic [LANES*IN_W-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*(N+2)-1:0]    out_data,
    output logic                      out_lazy
);

    localparam int RW = res_width(N);
    localparam logic signed [RW-1:0] MOD = RW'(modulus(N));

    logic                  en;
    logic                  v1;
    logic                  v2;
    logic                  lazy1;
    logic                  lazy2;
    logic [LANES*RW-1:0]   d1_next;
    logic [LANES*RW-1:0]   s1_q;
    logic [LANES*RW-1:0]   fold2;
    logic [LANES*RW-1:0]   s2_next;
    logic [LANES*RW-1:0]   s2_q;
    logic [LANES*RW-1:0]   s3_next;

    // Whole pipe moves together; it only stops when the output is held
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int IL = lane_lo(g, IN_W);
        localparam int RL = lane_lo(g, RW);

        logic signed [RW-1:0] d2;

        fermat_fold #(.N(N), .W_IN(IN_W)) u_fold1 (
            .x (in_data[IL +: IN_W]),
            .y (d1_next[RL +: RW])
        );

        fermat_fold #(.N(N), .W_IN(RW)) u_fold2 (
            .x (s1_q[RL +: RW]),
            .y (fold2[RL +: RW])
        );

        // Lazy beats keep the single-fold value; canonical beats refold
        assign s2_next[RL +: RW] = lazy1 ? s1_q[RL +: RW] : fold2[RL +: RW];

        // Only -1 can be negative after the refold; lift it into [0, 2^N]
        assign d2                = s2_q[RL +: RW];
        assign s3_next[RL +: RW] = (!lazy2 && d2[RW-1]) ? d2 + MOD : d2;
    end

    // Stage registers S1 fold, S2 refold, S3 correct/output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            lazy1     <= 1'b0;
            lazy2     <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            out_valid <= 1'b0;
            out_lazy  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            v1        <= in_valid;
            lazy1     <= in_lazy;
            s1_q      <= d1_next;
            v2        <= v1;
            lazy2     <= lazy1;
            s2_q      <= s2_next;
            out_valid <= v2;
            out_lazy  <= lazy2;
            out_data  <= s3_next;
        end
    end

endmodule

// File: tb/tb_fermat_reduce_pipe.sv
// tb/tb_fermat_reduce_pipe.sv - self-checking bench for fermat_reduce_pipe
module tb_fermat_reduce_pipe;

    localparam int L   = 4;
    localparam int N8  = 8;
    localparam int W8  = 17;
    localparam int R8  = 10;
    localparam int N16 = 16;
    localparam int W16 = 33;
    localparam int R16 = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              in_valid8, in_ready8, in_lazy8, out_valid8, out_ready8, out_lazy8;
    logic [L*W8-1:0]   in_data8;
    logic [L*R8-1:0]   out_data8;
    logic              in_valid16, in_ready16, in_lazy16, out_valid16, out_ready16, out_lazy16;
    logic [L*W16-1:0]  in_data16;
    logic [L*R16-1:0]  out_data16;

    fermat_reduce_pipe #(.N(N8), .LANES(L), .IN_W(W8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_lazy(in_lazy8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_lazy(out_lazy8)
    );

    fermat_reduce_pipe #(.N(N16), .LANES(L), .IN_W(W16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_lazy(in_lazy16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .out_lazy(out_lazy16)
    );

    typedef struct packed {
        logic             lazy;
        logic [3:0][31:0] x;
        logic [3:0][31:0] e;
    } vec_t;

    typedef struct packed {
        logic             lazy;
        logic             exact;
        logic [3:0][63:0] x;
        logic [3:0][63:0] e;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    vec_t tbl[6];

    int n_cmp  = 0;
    int n_bad  = 0;
    int wait8  = 0;
    int wait16 = 0;
    int outs8  = 0;
    int outs16 = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no/unexpected event expected clean completion", name);
    endtask

    function automatic longint pmod(input longint x, input longint m);
        longint r;
        r = x % m;
        return (r < 0) ? r + m : r;
    endfunction

    function automatic longint rnd(input int w);
        int     s;
        longint r;
        s = $urandom_range(0, 9);
        if (s == 0) return -(longint'(1) << (w - 1));
        if (s == 1) return (longint'(1) << (w - 1)) - 1;
        r = {$urandom(), $urandom()};
        return (r <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic vec_t mk(input logic lz, input int x0, input int x1, input int x2, input int x3,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.lazy = lz;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t   ex;
        longint t;
        ex.lazy  = v.lazy;
        ex.exact = 1'b1;
        for (int j = 0; j < 4; j++) begin
            t = $signed(v.x[j]); ex.x[j] = t;
            t = $signed(v.e[j]); ex.e[j] = t;
        end
        return ex;
    endfunction

    task automatic compare_beat(input string tag, input exp_t ex, input logic [3:0][63:0] act,
                                input logic act_lazy, input int n);
        longint m, a, x, lo, hi;
        m  = (longint'(1) << n) + 1;
        lo = (longint'(1) << n) - 1;
        hi = (longint'(1) << (n + 1)) - 1;
        check({tag, "_out_lazy"}, act_lazy, ex.lazy);
        for (int j = 0; j < 4; j++) begin
            a = $signed(act[j]);
            x = $signed(ex.x[j]);
            if (ex.exact) begin
                check($sformatf("%s_lane%0d_x%0d", tag, j, x), a, $signed(ex.e[j]));
            end else begin
                check($sformatf("%s_lane%0d_cong_x%0d", tag, j, x), pmod(a - x, m), 0);
                check($sformatf("%s_lane%0d_range_val%0d", tag, j, a), (a >= -lo && a <= hi) ? 1 : 0, 1);
            end
        end
    endtask

    // Scoreboard monitor for the N=8 instance
    always @(negedge clk) begin : mon8
        exp_t             ex;
        logic [3:0][63:0] act;
        longint           t;
        if (!rst && out_valid8 && out_ready8) begin
            outs8++;
            for (int j = 0; j < 4; j++) begin
                t = $signed(out_data8[j*R8 +: R8]);
                act[j] = t;
            end
            if (q8.size() == 0) fail_now("dut8_unexpected_beat");
            else begin
                ex = q8.pop_front();
                compare_beat("dut8", ex, act, out_lazy8, N8);
            end
        end
    end

    // Scoreboard monitor for the N=16 instance
    always @(negedge clk) begin : mon16
        exp_t             ex;
        logic [3:0][63:0] act;
        longint           t;
        if (!rst && out_valid16 && out_ready16) begin
            outs16++;
            for (int j = 0; j < 4; j++) begin
                t = $signed(out_data16[j*R16 +: R16]);
                act[j] = t;
            end
            if (q16.size() == 0) fail_now("dut16_unexpected_beat");
            else begin
                ex = q16.pop_front();
                compare_beat("dut16", ex, act, out_lazy16, N16);
            end
        end
    end

    task automatic send8(input exp_t ex);
        bit rdy, ok;
        ok = 0;
        in_lazy8 = ex.lazy;
        for (int j = 0; j < 4; j++) in_data8[j*W8 +: W8] = ex.x[j][W8-1:0];
        in_valid8 = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            rdy = in_ready8;
            @(posedge clk);
            #1;
            if (rdy) begin ok = 1; break; end
            wait8++;
        end
        in_valid8 = 1'b0;
        if (ok) q8.push_back(ex);
        else fail_now("dut8_send_timeout");
    endtask

    task automatic send16(input exp_t ex);
        bit rdy, ok;
        ok = 0;
        in_lazy16 = ex.lazy;
        for (int j = 0; j < 4; j++) in_data16[j*W16 +: W16] = ex.x[j][W16-1:0];
        in_valid16 = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            rdy = in_ready16;
            @(posedge clk);
            #1;
            if (rdy) begin ok = 1; break; end
            wait16++;
        end
        in_valid16 = 1'b0;
        if (ok) q16.push_back(ex);
        else fail_now("dut16_send_timeout");
    endtask

    function automatic exp_t rand_beat(input int n, input int w);
        exp_t   ex;
        longint x, m;
        m        = (longint'(1) << n) + 1;
        ex.lazy  = 1'($urandom_range(0, 1));
        ex.exact = !ex.lazy;
        for (int j = 0; j < 4; j++) begin
            x       = rnd(w);
            ex.x[j] = x;
            ex.e[j] = pmod(x, m);
        end
        return ex;
    endfunction

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (q8.size() == 0 && q16.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_q8_left", q8.size(), 0);
        check("drain_q16_left", q16.size(), 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got time limit expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          w8_0, w16_0, o;
        logic [39:0] exp_bus;

        in_valid8 = 0; in_lazy8 = 0; in_data8 = '0; out_ready8 = 1;
        in_valid16 = 0; in_lazy16 = 0; in_data16 = '0; out_ready16 = 1;
        rst = 0;
        #1 rst = 1;
        #1;
        check("rst_out_valid8", out_valid8, 0);
        check("rst_out_lazy8", out_lazy8, 0);
        check("rst_out_data8", longint'(out_data8), 0);
        check("rst_in_ready8", in_ready8, 1);
        check("rst_out_valid16", out_valid16, 0);
        check("rst_in_ready16", in_ready16, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        check("post_rst_in_ready8", in_ready8, 1);

        tbl[0] = mk(1'b0, 65535, -65536, 300, -1, 0, 256, 43, 256);
        tbl[1] = mk(1'b1, -65536, -255, 65535, 0, 256, 2, 0, 0);
        tbl[2] = mk(1'b0, 0, 257, 256, -257, 0, 0, 256, 0);
        tbl[3] = mk(1'b1, 256, 1, -1, 65280, -1, 1, 256, -255);
        tbl[4] = mk(1'b0, -65281, 65280, 12345, -12345, 254, 2, 9, 248);
        tbl[5] = mk(1'b1, -65281, 65280, 12345, -12345, 511, -255, 9, 248);

        // Exact latency in both modes from an empty pipe
        for (int i = 0; i < 2; i++) begin
            send8(to_exp(tbl[i]));
            @(posedge clk); #1;
            check($sformatf("lat_early_mode%0d", i), out_valid8, 0);
            @(posedge clk); #1;
            check($sformatf("lat_exact_mode%0d", i), out_valid8, 1);
            @(posedge clk); #1;
            check($sformatf("lat_single_mode%0d", i), out_valid8, 0);
        end

        // Back-to-back table stream, alternating modes, no stalls expected
        w8_0 = wait8;
        for (int i = 0; i < 6; i++) send8(to_exp(tbl[i]));
        drain();
        check("table_stream_stalls", wait8 - w8_0, 0);

        // Back-pressure: three beats inside, output held five cycles
        out_ready8 = 0;
        o = outs8;
        for (int i = 0; i < 3; i++) send8(to_exp(tbl[i]));
        for (int j = 0; j < 4; j++) exp_bus[j*R8 +: R8] = tbl[0].e[j][R8-1:0];
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_in_ready_c%0d", k), in_ready8, 0);
            check($sformatf("bp_out_valid_c%0d", k), out_valid8, 1);
            check($sformatf("bp_out_data_hold_c%0d", k), longint'(out_data8), longint'(exp_bus));
            check($sformatf("bp_out_lazy_hold_c%0d", k), out_lazy8, tbl[0].lazy);
            @(posedge clk); #1;
        end
        out_ready8 = 1;
        drain();
        check("bp_result_count", outs8 - o, 3);

        // Reset with two beats in flight
        out_ready8 = 0;
        send8(to_exp(tbl[3]));
        send8(to_exp(tbl[4]));
        @(posedge clk); #1;
        check("pre_rst_out_valid", out_valid8, 1);
        #2;
        rst = 1;
        q8.delete();
        #1;
        check("midrst_out_valid", out_valid8, 0);
        check("midrst_out_data", longint'(out_data8), 0);
        check("midrst_out_lazy", out_lazy8, 0);
        check("midrst_in_ready", in_ready8, 1);
        @(posedge clk); #1;
        check("in_rst_in_ready", in_ready8, 1);
        rst = 0;
        out_ready8 = 1;
        o = outs8;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_ghost_results", outs8 - o, 0);
        check("rst_after_out_valid", out_valid8, 0);

        // Random full-throughput streams on both instances
        w8_0  = wait8;
        w16_0 = wait16;
        fork
            begin
                for (int i = 0; i < 150; i++) send8(rand_beat(N8, W8));
            end
            begin
                for (int i = 0; i < 150; i++) send16(rand_beat(N16, W16));
            end
        join
        drain();
        check("rand8_stalls", wait8 - w8_0, 0);
        check("rand16_stalls", wait16 - w16_0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
